// File: rtl/lisa_dbg_cmd_responder.sv
// Purpose : ASCII debug-link responder; parses "wAAVVVV<LF>" / "rAA<LF>", drives the debug reg bus, answers reads "VVVV<CR><LF>".
// Latency : terminator pop -> reg_wr/reg_rd +2 cycles; read ack -> first response byte +1 cycle (tx_buf_empty=1).
// Backpr. : pops RX only while parsing, one blank cycle after every pop; SEND stalls on tx_buf_empty=0 with no loss.
// Option  : define DBG_HEX_UPPER_EN to also accept 'A'-'F' digits and 'W'/'R' commands (response stays lowercase).
module lisa_dbg_cmd_responder #(
    parameter int unsigned ACK_TO  = 64,
    parameter logic [15:0] TO_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_d,
    input  logic        rx_avail,
    output logic        rx_rd,
    output logic [7:0]  tx_d,
    output logic        tx_wr,
    input  logic        tx_buf_empty,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    input  logic        reg_ack,
    output logic        busy
);

    localparam int unsigned TO_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_W_A1, S_W_A2, S_W_D1, S_W_D2, S_W_D3, S_W_D4, S_W_END,
        S_R_A1, S_R_A2, S_R_END, S_EXEC_W, S_EXEC_R, S_WAIT_ACK, S_SEND, S_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_vld_q, byte_vld_d;
    logic [7:0]        addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [7:0]        tx_hold_q, tx_hold_d;
    logic              tx_blank_q, tx_blank_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic [4:0]        hex;
    logic              hex_ok;
    logic              is_w, is_r, is_eol;
    logic              parsing, pop, tx_push, ack_expired;
    logic [7:0]        tx_char;

    // Returns {valid, nibble} for an ASCII hex digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
        else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, c[3:0] + 4'd9};
`ifdef DBG_HEX_UPPER_EN
        else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
`endif
        return r;
    endfunction

    // Lowercase ASCII for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // The byte popped last cycle is decoded in the following (blank) cycle.
    assign hex    = hex_decode(byte_q);
    assign hex_ok = hex[4];
    assign is_eol = (byte_q == 8'h0A) || (byte_q == 8'h0D);
`ifdef DBG_HEX_UPPER_EN
    assign is_w = (byte_q == 8'h77) || (byte_q == 8'h57);
    assign is_r = (byte_q == 8'h72) || (byte_q == 8'h52);
`else
    assign is_w = (byte_q == 8'h77);
    assign is_r = (byte_q == 8'h72);
`endif

    // RX is only drained in the parsing/flush states, never during exec or response.
    assign parsing = !(state_q inside {S_EXEC_W, S_EXEC_R, S_WAIT_ACK, S_SEND});
    assign pop     = parsing && rx_avail && !byte_vld_q;
    assign tx_push = (state_q == S_SEND) && tx_buf_empty && !tx_blank_q;
    assign ack_expired = (ACK_TO != 0) && (to_cnt_q == TO_W'(ACK_TO - 1));

    // Response byte selected by the byte counter: four digits MSB first, then CR, LF.
    always_comb begin
        case (tx_cnt_q)
            3'd0:    tx_char = hex_char(rdata_q[15:12]);
            3'd1:    tx_char = hex_char(rdata_q[11:8]);
            3'd2:    tx_char = hex_char(rdata_q[7:4]);
            3'd3:    tx_char = hex_char(rdata_q[3:0]);
            3'd4:    tx_char = 8'h0D;
            default: tx_char = 8'h0A;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; parsing states advance only on a freshly latched byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (byte_vld_q) begin
                    if (is_w)                              state_d = S_W_A1;
                    else if (is_r)                         state_d = S_R_A1;
                    else if (!(is_eol || byte_q == 8'h20)) state_d = S_FLUSH;
                end
            end
            S_W_A1:     if (byte_vld_q) state_d = hex_ok ? S_W_A2  : S_FLUSH;
            S_W_A2:     if (byte_vld_q) state_d = hex_ok ? S_W_D1  : S_FLUSH;
            S_W_D1:     if (byte_vld_q) state_d = hex_ok ? S_W_D2  : S_FLUSH;
            S_W_D2:     if (byte_vld_q) state_d = hex_ok ? S_W_D3  : S_FLUSH;
            S_W_D3:     if (byte_vld_q) state_d = hex_ok ? S_W_D4  : S_FLUSH;
            S_W_D4:     if (byte_vld_q) state_d = hex_ok ? S_W_END : S_FLUSH;
            S_W_END:    if (byte_vld_q) state_d = is_eol ? S_EXEC_W : S_FLUSH;
            S_R_A1:     if (byte_vld_q) state_d = hex_ok ? S_R_A2  : S_FLUSH;
            S_R_A2:     if (byte_vld_q) state_d = hex_ok ? S_R_END : S_FLUSH;
            S_R_END:    if (byte_vld_q) state_d = is_eol ? S_EXEC_R : S_FLUSH;
            S_EXEC_W:   state_d = S_IDLE;
            S_EXEC_R:   state_d = reg_ack ? S_SEND : S_WAIT_ACK;
            S_WAIT_ACK: if (reg_ack || ack_expired) state_d = S_SEND;
            S_SEND:     if (tx_push && tx_cnt_q == 3'd5) state_d = S_IDLE;
            S_FLUSH:    if (byte_vld_q && byte_q == 8'h0A) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath next values: byte latch, address/data assembly, read capture, TX sequencing.
    always_comb begin
        byte_d     = pop ? rx_d : byte_q;
        byte_vld_d = pop;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        if (byte_vld_q && hex_ok) begin
            if (state_q == S_W_A1 || state_q == S_R_A1) addr_d = {hex[3:0], addr_q[3:0]};
            if (state_q == S_W_A2 || state_q == S_R_A2) addr_d = {addr_q[7:4], hex[3:0]};
            if (state_q inside {S_W_D1, S_W_D2, S_W_D3, S_W_D4}) wdata_d = {wdata_q[11:0], hex[3:0]};
        end
        if ((state_q == S_EXEC_R || state_q == S_WAIT_ACK) && reg_ack) rdata_d = reg_rdata;
        else if (state_q == S_WAIT_ACK && ack_expired)                  rdata_d = TO_DATA;
        to_cnt_d   = (state_q == S_WAIT_ACK) ? to_cnt_q + TO_W'(1) : '0;
        tx_cnt_d   = (state_q != S_SEND) ? 3'd0 : (tx_push ? tx_cnt_q + 3'd1 : tx_cnt_q);
        tx_blank_d = tx_push;
        tx_hold_d  = tx_push ? tx_char : tx_hold_q;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q     <= 8'h00;
            byte_vld_q <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 16'h0000;
            rdata_q    <= 16'h0000;
            tx_hold_q  <= 8'h00;
            tx_blank_q <= 1'b0;
            tx_cnt_q   <= 3'd0;
            to_cnt_q   <= '0;
        end else begin
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tx_hold_q  <= tx_hold_d;
            tx_blank_q <= tx_blank_d;
            tx_cnt_q   <= tx_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Outputs; tx_d shows the byte being pushed, otherwise holds the last one.
    always_comb begin
        rx_rd     = pop;
        tx_wr     = tx_push;
        tx_d      = tx_push ? tx_char : tx_hold_q;
        reg_wr    = (state_q == S_EXEC_W);
        reg_rd    = (state_q == S_EXEC_R);
        busy      = (state_q != S_IDLE);
        reg_addr  = addr_q;
        reg_wdata = wdata_q;
    end

endmodule
